// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered MIPS immediate extension with 2-entry valid/ready skid buffer
// Optional feature macro: BRANCH_SHIFT_EN (mode 11 shifts the sign-extended value left by 2)
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);

  localparam int SH = OUT_W - IN_W;

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] ext_data;
  logic             ext_neg;

  logic [1:0]       count;
  logic [OUT_W-1:0] head_data;
  logic             head_neg;
  logic [OUT_W-1:0] skid_data;
  logic             skid_neg;
  logic             push;
  logic             pop;

  // Casts avoid zero-width replication when IN_W == OUT_W.
  always_comb begin
    sign_ext  = OUT_W'($signed(in_imm));
    zero_ext  = OUT_W'(in_imm);
    upper_ext = zero_ext << SH;
    ext_neg   = in_imm[IN_W-1];
    case (in_mode)
      2'b00:   ext_data = sign_ext;
      2'b01:   ext_data = zero_ext;
      2'b10:   ext_data = upper_ext;
`ifdef BRANCH_SHIFT_EN
      default: ext_data = sign_ext << 2;
`else
      default: ext_data = sign_ext;
`endif
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage carries no reset; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (pop && count == 2'd2) begin
        head_data <= skid_data;
        head_neg  <= skid_neg;
      end else if (push && (count == 2'd0 || pop)) begin
        head_data <= ext_data;
        head_neg  <= ext_neg;
      end
      if (push && count == 2'd1 && !pop) begin
        skid_data <= ext_data;
        skid_neg  <= ext_neg;
      end
    end
  end

  assign out_data = out_valid ? head_data : '0;
  assign out_neg  = out_valid & head_neg;

endmodule
